// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-bus source driver.
package cpu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } bus_state_t;

  // Width of a register index field; a single register still needs one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_bus_mux.sv
// Combinational source selector for the bus driver.
// Source indices beyond NUM_REGS read as zero.
// With CPU_BUS_DRIVER_ERR_EN defined it also flags an out-of-range register source.
module cpu_bus_mux #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int SEL_W    = cpu_pkg::sel_w(NUM_REGS)
) (
  input  logic [NUM_REGS*DATA_W-1:0] reg_q_i,
  input  logic [SEL_W-1:0]           src_i,
  input  logic                       imm_sel_i,
  input  logic [DATA_W-1:0]          imm_i,
`ifdef CPU_BUS_DRIVER_ERR_EN
  output logic                       src_oor_o,
`endif
  output logic [DATA_W-1:0]          data_o
);
  localparam int SLOTS = 2 ** SEL_W;

  // Full index space padded with zeros, so no range compare is needed.
  logic [SLOTS-1:0][DATA_W-1:0] tbl;
`ifdef CPU_BUS_DRIVER_ERR_EN
  logic [SLOTS-1:0] in_rng;
`endif

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_REGS) begin : g_reg
      assign tbl[i] = reg_q_i[i*DATA_W +: DATA_W];
`ifdef CPU_BUS_DRIVER_ERR_EN
      assign in_rng[i] = 1'b1;
`endif
    end else begin : g_pad
      assign tbl[i] = '0;
`ifdef CPU_BUS_DRIVER_ERR_EN
      assign in_rng[i] = 1'b0;
`endif
    end
  end

  assign data_o = imm_sel_i ? imm_i : tbl[src_i];
`ifdef CPU_BUS_DRIVER_ERR_EN
  assign src_oor_o = ~imm_sel_i & ~in_rng[src_i];
`endif

endmodule

// File: rtl/cpu_bus_driver.sv
// Source side of the CPU data bus: accepts one transfer command and drives the
// value for a settle cycle. It then pulses the one-hot load enable of the
// destination and signals done.
// Optional macro CPU_BUS_DRIVER_ERR_EN adds an err pulse for out-of-range indices.
module cpu_bus_driver #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int SEL_W    = cpu_pkg::sel_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_imm_sel,
  input  logic [DATA_W-1:0]          cmd_imm,
  input  logic [SEL_W-1:0]           cmd_src,
  input  logic [SEL_W-1:0]           cmd_dst,
  input  logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_valid,
  output logic [NUM_REGS-1:0]        load_en,
`ifdef CPU_BUS_DRIVER_ERR_EN
  output logic                       err,
`endif
  output logic                       done
);
  import cpu_pkg::*;

  bus_state_t            state_q;
  logic [SEL_W-1:0]      dst_q;
  logic [DATA_W-1:0]     bus_data_q, bus_data_d;
  logic                  bus_valid_q;
  logic [NUM_REGS-1:0]   load_en_q, dst_oh_d;
  logic                  done_q;
`ifdef CPU_BUS_DRIVER_ERR_EN
  logic                  src_oor_d, src_oor_q, err_q;
`endif

  cpu_bus_mux #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W)
  ) u_mux (
    .reg_q_i   (reg_q),
    .src_i     (cmd_src),
    .imm_sel_i (cmd_imm_sel),
    .imm_i     (cmd_imm),
`ifdef CPU_BUS_DRIVER_ERR_EN
    .src_oor_o (src_oor_d),
`endif
    .data_o    (bus_data_d)
  );

  // One-hot decode of the latched destination; indices >= NUM_REGS decode to zero.
  always_comb begin
    dst_oh_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(dst_q) == i) dst_oh_d[i] = 1'b1;
  end

  // Transfer FSM with registered outputs: IDLE -> DRIVE (settle) -> LOAD -> IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      dst_q       <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      load_en_q   <= '0;
      done_q      <= 1'b0;
`ifdef CPU_BUS_DRIVER_ERR_EN
      src_oor_q   <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          load_en_q <= '0;
`ifdef CPU_BUS_DRIVER_ERR_EN
          err_q     <= 1'b0;
`endif
          if (cmd_valid) begin
            // reg_q is sampled only here; later changes do not reach the bus.
            dst_q       <= cmd_dst;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= 1'b1;
`ifdef CPU_BUS_DRIVER_ERR_EN
            src_oor_q   <= src_oor_d;
`endif
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          load_en_q <= dst_oh_d;
          state_q   <= LOAD;
        end
        LOAD: begin
          load_en_q   <= '0;
          bus_valid_q <= 1'b0;
          done_q      <= 1'b1;
`ifdef CPU_BUS_DRIVER_ERR_EN
          err_q       <= src_oor_q | ~(|dst_oh_d);
`endif
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is held low for as long as reset is applied, not just after the edge.
  assign cmd_ready = reset & (state_q == IDLE);
  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;
  assign load_en   = load_en_q;
  assign done      = done_q;
`ifdef CPU_BUS_DRIVER_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_cpu_bus_driver.sv
// Directed bench for cpu_bus_driver: a 4-register instance and a 3-register instance.
module tb_cpu_bus_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_imm_sel;
  logic [3:0]  cmd_imm;
  logic [1:0]  cmd_src, cmd_dst;

  logic        cv4, rdy4, bv4, done4;
  logic [15:0] rq4;
  logic [3:0]  bd4, le4;
  logic        cv3, rdy3, bv3, done3;
  logic [11:0] rq3;
  logic [3:0]  bd3;
  logic [2:0]  le3;
`ifdef CPU_BUS_DRIVER_ERR_EN
  logic        err4, err3;
`endif

  logic [3:0]  bank4 [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_bus_driver #(.NUM_REGS(4)) u_dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cv4), .cmd_ready(rdy4),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .reg_q(rq4), .bus_data(bd4), .bus_valid(bv4), .load_en(le4),
`ifdef CPU_BUS_DRIVER_ERR_EN
    .err(err4),
`endif
    .done(done4));

  cpu_bus_driver #(.NUM_REGS(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cv3), .cmd_ready(rdy3),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .reg_q(rq3), .bus_data(bd3), .bus_valid(bv3), .load_en(le3),
`ifdef CPU_BUS_DRIVER_ERR_EN
    .err(err3),
`endif
    .done(done3));

  // Register bank model fed by the 4-register driver.
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (le4[i]) bank4[i] <= bd4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cv4 = 1'b1; cv3 = 1'b1;
    cmd_imm_sel = 1'b1; cmd_imm = 4'h7; cmd_src = 2'd0; cmd_dst = 2'd0;
    tick(); tick();
    checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", rdy4); end
    checks++; if (le4 !== 4'b0000) begin failures++; $display("FAIL rst_load_en got=%b exp=0000", le4); end
    checks++; if (bv4 !== 1'b0) begin failures++; $display("FAIL rst_bus_valid got=%b exp=0", bv4); end
    checks++; if (bd4 !== 4'h0) begin failures++; $display("FAIL rst_bus_data got=%h exp=0", bd4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done4); end
    reset = 1'b1; cv4 = 1'b0; cv3 = 1'b0;
    #1;
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", rdy4); end
    tick();
    checks++; if (bv4 !== 1'b0) begin failures++; $display("FAIL rst_stale_cmd bus_valid got=%b exp=0", bv4); end
  endtask

  task automatic test_imm_load();
    cmd_imm_sel = 1'b1; cmd_imm = 4'hA; cmd_dst = 2'd2; cmd_src = 2'd0; cv4 = 1'b1;
    tick(); cv4 = 1'b0;
    checks++; if (bd4 !== 4'hA || bv4 !== 1'b1 || le4 !== 4'b0000)
      begin failures++; $display("FAIL imm_n1 got data=%h valid=%b le=%b exp data=a valid=1 le=0000", bd4, bv4, le4); end
    checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL imm_n1_ready got=%b exp=0", rdy4); end
    tick();
    checks++; if (le4 !== 4'b0100 || bv4 !== 1'b1) begin failures++; $display("FAIL imm_n2_load_en got=%b valid=%b exp=0100 valid=1", le4, bv4); end
    tick();
    checks++; if (done4 !== 1'b1 || rdy4 !== 1'b1 || bv4 !== 1'b0)
      begin failures++; $display("FAIL imm_n3 got done=%b ready=%b valid=%b exp 1 1 0", done4, rdy4, bv4); end
    checks++; if (bank4[2] !== 4'hA) begin failures++; $display("FAIL imm_r2 got=%h exp=a", bank4[2]); end
    tick();
    checks++; if (done4 !== 1'b0 || bd4 !== 4'hA) begin failures++; $display("FAIL imm_done_pulse got done=%b data=%h exp done=0 data=a", done4, bd4); end
  endtask

  task automatic test_reg_copy();
    rq4 = 16'h0050; cmd_imm_sel = 1'b0; cmd_imm = 4'h7; cmd_src = 2'd1; cmd_dst = 2'd3; cv4 = 1'b1;
    tick(); cv4 = 1'b0; rq4 = 16'h00F0;
    checks++; if (bd4 !== 4'h5) begin failures++; $display("FAIL copy_n1_data got=%h exp=5", bd4); end
    tick();
    checks++; if (le4 !== 4'b1000 || bd4 !== 4'h5) begin failures++; $display("FAIL copy_n2 got le=%b data=%h exp 1000 5", le4, bd4); end
    tick();
    checks++; if (done4 !== 1'b1 || bank4[3] !== 4'h5) begin failures++; $display("FAIL copy_n3 got done=%b r3=%h exp 1 5", done4, bank4[3]); end
  endtask

  task automatic test_back_to_back();
    cmd_imm_sel = 1'b1; cmd_imm = 4'h3; cmd_dst = 2'd0; cv4 = 1'b1;
    tick();
    cmd_imm = 4'hC; cmd_dst = 2'd1;
    checks++; if (bd4 !== 4'h3 || rdy4 !== 1'b0) begin failures++; $display("FAIL b2b_n1 got data=%h ready=%b exp 3 0", bd4, rdy4); end
    tick();
    checks++; if (le4 !== 4'b0001 || bd4 !== 4'h3) begin failures++; $display("FAIL b2b_n2 got le=%b data=%h exp 0001 3", le4, bd4); end
    tick();
    checks++; if (done4 !== 1'b1 || rdy4 !== 1'b1) begin failures++; $display("FAIL b2b_n3 got done=%b ready=%b exp 1 1", done4, rdy4); end
    tick(); cv4 = 1'b0;
    checks++; if (bd4 !== 4'hC || bv4 !== 1'b1 || done4 !== 1'b0)
      begin failures++; $display("FAIL b2b_n4 got data=%h valid=%b done=%b exp c 1 0", bd4, bv4, done4); end
    tick();
    checks++; if (le4 !== 4'b0010) begin failures++; $display("FAIL b2b_n5_load_en got=%b exp=0010", le4); end
    tick();
    checks++; if (done4 !== 1'b1 || bank4[1] !== 4'hC || bank4[0] !== 4'h3)
      begin failures++; $display("FAIL b2b_n6 got done=%b r1=%h r0=%h exp 1 c 3", done4, bank4[1], bank4[0]); end
  endtask

  task automatic test_reset_in_load();
    cmd_imm_sel = 1'b1; cmd_imm = 4'h9; cmd_dst = 2'd2; cv4 = 1'b1;
    tick(); cv4 = 1'b0;
    tick();
    checks++; if (le4 !== 4'b0100) begin failures++; $display("FAIL rld_n2_load_en got=%b exp=0100", le4); end
    reset = 1'b0;
    tick();
    checks++; if (le4 !== 4'b0000 || bv4 !== 1'b0 || done4 !== 1'b0 || bd4 !== 4'h0)
      begin failures++; $display("FAIL rld_n3 got le=%b valid=%b done=%b data=%h exp 0000 0 0 0", le4, bv4, done4, bd4); end
    reset = 1'b1;
    #1;
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL rld_release_ready got=%b exp=1", rdy4); end
    tick();
    checks++; if (done4 !== 1'b0 || bv4 !== 1'b0) begin failures++; $display("FAIL rld_no_done got done=%b valid=%b exp 0 0", done4, bv4); end
  endtask

  task automatic test_out_of_range();
    rq3 = 12'h321;
    // dst beyond the 3-register range: no enable, done still pulses
    cmd_imm_sel = 1'b1; cmd_imm = 4'h6; cmd_dst = 2'd3; cmd_src = 2'd0; cv3 = 1'b1;
    tick(); cv3 = 1'b0;
    checks++; if (bd3 !== 4'h6 || le3 !== 3'b000) begin failures++; $display("FAIL oor_dst_n1 got data=%h le=%b exp 6 000", bd3, le3); end
    tick();
    checks++; if (le3 !== 3'b000 || bv3 !== 1'b1) begin failures++; $display("FAIL oor_dst_n2 got le=%b valid=%b exp 000 1", le3, bv3); end
    tick();
    checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL oor_dst_done got=%b exp=1", done3); end
`ifdef CPU_BUS_DRIVER_ERR_EN
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL oor_dst_err got=%b exp=1", err3); end
`endif
    // in-range dst: normal enable, no error
    cmd_dst = 2'd1; cv3 = 1'b1;
    tick(); cv3 = 1'b0;
    tick();
    checks++; if (le3 !== 3'b010) begin failures++; $display("FAIL inr_dst_load_en got=%b exp=010", le3); end
    tick();
    checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL inr_dst_done got=%b exp=1", done3); end
`ifdef CPU_BUS_DRIVER_ERR_EN
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL inr_dst_err got=%b exp=0", err3); end
`endif
    // register source beyond range reads as zero
    cmd_imm_sel = 1'b0; cmd_src = 2'd3; cmd_dst = 2'd0; cv3 = 1'b1;
    tick(); cv3 = 1'b0;
    checks++; if (bd3 !== 4'h0 || bv3 !== 1'b1) begin failures++; $display("FAIL oor_src_data got=%h valid=%b exp 0 1", bd3, bv3); end
    tick(); tick();
    checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL oor_src_done got=%b exp=1", done3); end
`ifdef CPU_BUS_DRIVER_ERR_EN
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL oor_src_err got=%b exp=1", err3); end
`endif
    // in-range register source on the same instance
    cmd_src = 2'd2; cv3 = 1'b1;
    tick(); cv3 = 1'b0;
    checks++; if (bd3 !== 4'h3) begin failures++; $display("FAIL inr_src_data got=%h exp=3", bd3); end
    tick(); tick();
  endtask

  initial begin
    reset = 1'b0; cv4 = 1'b0; cv3 = 1'b0; rq4 = '0; rq3 = '0;
    cmd_imm_sel = 1'b0; cmd_imm = '0; cmd_src = '0; cmd_dst = '0;
    for (int i = 0; i < 4; i++) bank4[i] = 4'h0;
    #2;
    test_reset();
    test_imm_load();
    test_reg_copy();
    test_back_to_back();
    test_reset_in_load();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bus_driver.md
Name: cpu_bus_driver

Overview:
Source side of the 4-bit CPU data bus. Takes one transfer command per handshake. The source is either a register output or an immediate. The block drives the value onto the bus, then pulses the one-hot load enable of the destination register. It sits between the control unit and the register bank, and feeds the registers' D inputs and enable inputs.

Parameters:
NUM_REGS, 4, number of bus registers addressed (2..16)
DATA_W, 4, bus width in bits
SEL_W, clog2(NUM_REGS), width of the source and destination index fields

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_imm_sel  input  1  1 = source is cmd_imm, 0 = source is reg_q[cmd_src]
cmd_imm  input  DATA_W  immediate value
cmd_src  input  SEL_W  source register index
cmd_dst  input  SEL_W  destination register index
reg_q  input  NUM_REGS*DATA_W  flattened register outputs, reg i at bits [i*DATA_W +: DATA_W]
bus_data  output  DATA_W  value driven to register D inputs
bus_valid  output  1  bus_data is being driven for a transfer
load_en  output  NUM_REGS  one-hot destination enable
done  output  1  one-cycle pulse, transfer complete

Behaviour:
- Reset is synchronous and active-low. On any edge with reset=0:
  - state=IDLE, bus_data=0, bus_valid=0, load_en=0, done=0.
  - cmd_ready is forced to 0 while reset=0.
- States:
  - IDLE: cmd_ready=1.
  - DRIVE: bus_valid=1, load_en=0.
  - LOAD: bus_valid=1, load_en=onehot(dst).
- Handshake: a command is accepted on the edge where cmd_valid & cmd_ready. The master holds the fields stable until then. cmd_valid in DRIVE or LOAD is ignored.
- At the accept edge:
  - Latch dst.
  - Register bus_data = cmd_imm_sel ? cmd_imm : reg_q[cmd_src]. reg_q is sampled at that edge only.
  - Go to DRIVE.
- DRIVE -> LOAD unconditionally. bus_data is stable one full cycle before any enable, which gives a settle cycle.
- LOAD -> IDLE unconditionally. The destination register captures at the end of the LOAD cycle. done=1 for exactly the first IDLE cycle after LOAD.
- Timing, accept at cycle N:
  - N+1: bus_data valid, DRIVE.
  - N+2: load_en asserted.
  - N+3: done=1, cmd_ready=1, destination Q updated.
  - Max throughput is one transfer per 3 cycles. A command can be accepted in the same cycle done is high.
- bus_data keeps its last value in IDLE; bus_valid=0 there.
- Boundary conditions:
  - src == dst: legal; the register reloads its own value.
  - dst >= NUM_REGS (non-power-of-two NUM_REGS): load_en stays 0 in LOAD and done still pulses.
  - src >= NUM_REGS with imm_sel=0: bus_data=0.
  - Reset mid-transfer (DRIVE or LOAD): next cycle is IDLE with all outputs zero. No done pulse; the command is lost.
- load_en is never more than one-hot, and is never nonzero outside LOAD.

Optional Feature:
- Macro CPU_BUS_DRIVER_ERR_EN.
- Defined: adds output err (1 bit, reset 0). err pulses in the same cycle as done when the latched dst >= NUM_REGS, or when imm_sel=0 and src >= NUM_REGS.
- Undefined: no err port, no range-flag storage; out-of-range behaviour as above.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W = 4.
  - The bus_state_t enum (IDLE, DRIVE, LOAD).
  - The SEL_W width function.
- One natural sub-module: cpu_bus_mux, a combinational source selector. It takes reg_q, src and imm/imm_sel and produces the next bus value, including out-of-range zeroing.

Test Plan:
1. Reset: reset=0 for 2 cycles with cmd_valid=1 -> cmd_ready=0, load_en=0000, bus_valid=0, bus_data=0. Release -> cmd_ready=1, no transfer from the stale command.
2. Immediate load: imm_sel=1, imm=4'hA, dst=2 accepted at N.
   - N+1: bus_data=A, bus_valid=1, load_en=0000.
   - N+2: load_en=0100.
   - N+3: done=1 and register model R2=A.
3. Register copy: R1=4'h5, imm_sel=0, src=1, dst=3 -> bus_data=5 from N+1; load_en=1000 at N+2. Changing reg_q[1] to 4'hF at N+1 does not change bus_data.
4. Back-to-back: cmd_valid held high with two queued commands -> first accepted at N. Requests at N+1 and N+2 are ignored. Second is accepted at N+3, the same cycle as done.
5. Reset asserted in LOAD (N+2) -> at N+3 load_en=0000, bus_valid=0, done=0, cmd_ready=1 after release.
6. NUM_REGS=3, dst=3 -> load_en=000 throughout and done=1 at N+3. With CPU_BUS_DRIVER_ERR_EN, err=1 at N+3; with dst=1, err=0.
